adder_arb: RTL and testbench
============================

ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 The block SHALL read the DSIZE width from the shared define file (default 16), the operand and result width.
REQ-002 The block SHALL provide port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 The block SHALL provide port rst, input, 1: asynchronous reset, active-high.
REQ-004 The block SHALL provide ports req0 and req1, input, 1 each: requester 0 and 1 add requests, held high until granted.
REQ-005 The block SHALL provide ports a0, b0, a1, b1, input, DSIZE each: requester operands, stable while the matching req is high.
REQ-006 The block SHALL provide ports gnt0 and gnt1, output, 1 each: single-cycle accept pulse to the matching requester.
REQ-007 The block SHALL provide port res, output, DSIZE: registered sum.
REQ-008 The block SHALL provide port res_cout, output, 1: carry-out of the registered sum.
REQ-009 The block SHALL provide port res_id, output, 1: index of the requester owning res.
REQ-010 The block SHALL provide port res_valid, output, 1: res, res_cout and res_id are valid.
REQ-011 The block SHALL provide port res_ready, input, 1: the consumer takes the result this cycle.

Function
REQ-012 The FSM SHALL have two states, IDLE (no held result) and HOLD (result held, res_valid=1).
REQ-013 The block SHALL accept a request when the state is IDLE, or when it is HOLD with res_ready=1 (back-to-back, no bubble).
REQ-014 On accept, exactly one gnt SHALL pulse combinationally in that cycle, with no more than one gnt high per cycle.
REQ-015 On the edge ending an accept cycle, the block SHALL register res = (a+b) mod 2^DSIZE and res_cout = bit DSIZE of the (DSIZE+1)-bit sum of the granted operands, load res_id with the winner, and enter HOLD.
REQ-016 Latency SHALL be 1 cycle: gnt in cycle N gives res_valid=1 in cycle N+1.
REQ-017 In HOLD with res_ready=0, res, res_cout and res_id SHALL hold unchanged and gnt0 and gnt1 SHALL stay 0.
REQ-018 In HOLD with res_ready=1 and no request pending, the FSM SHALL return to IDLE and clear res_valid next cycle.
REQ-019 With no request in IDLE, outputs SHALL hold and gnt0=gnt1=0.
REQ-020 On simultaneous req0 and req1, arbitration SHALL follow REQ-026 or REQ-027.
REQ-021 A requester SHALL drop req, or present a new operation, only in the cycle after its gnt, and the block SHALL NOT latch operands at any other time.
REQ-022 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-023 While rst=1, regardless of clk, the state SHALL be IDLE and the outputs SHALL be res=0, res_cout=0, res_id=0, res_valid=0, gnt0=0, gnt1=0.
REQ-024 Reset asserted mid-HOLD SHALL discard the held result, and the block SHALL accept no request until the first clk edge after rst falls.
REQ-025 The round-robin pointer SHALL reset to favour requester 0.

Configuration
REQ-026 With macro ADDER_ARB_RR_EN defined, arbitration SHALL be round-robin: a 1-bit pointer names the last winner, and on contention the other requester wins.
REQ-027 With ADDER_ARB_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 always winning contention, and the pointer logic is absent.

Verification
REQ-028 Scenario single op: req0=1, a0=16'h0005, b0=16'h0003 -> gnt0 pulse in cycle N; cycle N+1 res=16'h0008, res_cout=0, res_id=0, res_valid=1.
REQ-029 Scenario wrap-around: req1=1, a1=16'hFFFF, b1=16'h0002 -> res=16'h0001, res_cout=1, res_id=1.
REQ-030 Scenario contention: req0=req1=1 held for four accepts with res_ready=1 -> with RR_EN the gnt order is 0,1,0,1; without RR_EN the order is 0,0,0,0 while req0 stays high.
REQ-031 Scenario backpressure: result held with res_ready=0 for 3 cycles while req1=1 -> no gnt and res stable; res_ready=1 -> gnt1 in that same cycle and the new res the next cycle.
REQ-032 Scenario reset: rst pulsed asynchronously between edges while res_valid=1 -> res_valid=0 and res=0 immediately; requests pending during rst are granted only after rst falls.

Source files
------------

// File: rtl/adder_arb_if.sv
// Handshake bundle between the two requesters, the result consumer and adder_arb.
// Operand/result width comes from the shared DSIZE define (16 when not set elsewhere).
`ifndef DSIZE
`define DSIZE 16
`endif

interface adder_arb_if #(
  parameter int DSIZE = `DSIZE
);
  logic             req0;
  logic             req1;
  logic [DSIZE-1:0] a0;
  logic [DSIZE-1:0] b0;
  logic [DSIZE-1:0] a1;
  logic [DSIZE-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic [DSIZE-1:0] res;
  logic             res_cout;
  logic             res_id;
  logic             res_valid;
  logic             res_ready;

  // slave: the arbiter/adder itself
  modport slave (
    input  req0, req1, a0, b0, a1, b1, res_ready,
    output gnt0, gnt1, res, res_cout, res_id, res_valid
  );

  // master: requesters plus result consumer
  modport master (
    output req0, req1, a0, b0, a1, b1, res_ready,
    input  gnt0, gnt1, res, res_cout, res_id, res_valid
  );
endinterface

// File: rtl/adder_arb.sv
// Two-requester arbitrated adder with a one-entry registered result.
// Define ADDER_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
`ifndef DSIZE
`define DSIZE 16
`endif

module adder_arb (
  input  logic        clk,
  input  logic        rst,
  adder_arb_if.slave  bus,
  output logic        dbg_state
);
  localparam int DSIZE = `DSIZE;

  // Handshake: a request is accepted in a cycle where reqN is high and gntN pulses;
  // the result is taken in a cycle where res_valid and res_ready are both high.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept_ok;
  logic             pick1;
  logic             gnt0_c;
  logic             gnt1_c;
  logic [DSIZE:0]   sum;
  logic [DSIZE-1:0] res_q;
  logic             cout_q;
  logic             id_q;

`ifdef ADDER_ARB_RR_EN
  // ptr holds the last winner; it resets to 1 so requester 0 wins the first contention
  logic ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b1;
    end else if (gnt0_c || gnt1_c) begin
      ptr <= gnt1_c;
    end
  end

  always_comb begin
    pick1 = bus.req1 & (~bus.req0 | ~ptr);
  end
`else
  always_comb begin
    pick1 = bus.req1 & ~bus.req0;
  end
`endif

  always_comb begin
    accept_ok = 1'b0;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    state_nxt = state;
    sum       = '0;

    // grants stay low while rst is high, even though the state already reads IDLE
    accept_ok = ~rst & ((state == IDLE) | ((state == HOLD) & bus.res_ready));
    gnt1_c    = accept_ok & pick1;
    gnt0_c    = accept_ok & bus.req0 & ~pick1;

    if (gnt1_c) begin
      sum = {1'b0, bus.a1} + {1'b0, bus.b1};
    end else begin
      sum = {1'b0, bus.a0} + {1'b0, bus.b0};
    end

    if (gnt0_c || gnt1_c) begin
      state_nxt = HOLD;
    end else if ((state == HOLD) && bus.res_ready) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q  <= '0;
      cout_q <= 1'b0;
      id_q   <= 1'b0;
    end else if (gnt0_c || gnt1_c) begin
      res_q  <= sum[DSIZE-1:0];
      cout_q <= sum[DSIZE];
      id_q   <= gnt1_c;
    end
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.res       = res_q;
  assign bus.res_cout  = cout_q;
  assign bus.res_id    = id_q;
  assign bus.res_valid = (state == HOLD);
  assign dbg_state     = state;

endmodule

// File: tb/tb_adder_arb.sv
// Self-checking bench for adder_arb: directed scenarios plus random traffic,
// with a scoreboard that predicts every result from the granted operands.
`ifndef DSIZE
`define DSIZE 16
`endif

module tb_adder_arb;
  localparam int DSIZE = `DSIZE;
  localparam int W     = DSIZE + 2;

  logic clk = 1'b0;
  logic rst;
  logic dbg_state;

  adder_arb_if #(.DSIZE(DSIZE)) bus ();

  adder_arb dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // scoreboard entries are {res_id, res_cout, res}
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  logic         pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if (exp_q.size() == 0 || bus.res_valid !== 1'b1) begin
          errors++;
          $display("FAIL sb_latency: res_valid=%b queued=%0d, required res_valid=1 with a queued result",
                   bus.res_valid, exp_q.size());
          if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.res_id, bus.res_cout, bus.res} !== exp_v) begin
            errors++;
            $display("FAIL sb_result: got id=%b cout=%b res=%h, required id=%b cout=%b res=%h",
                     bus.res_id, bus.res_cout, bus.res, exp_v[W-1], exp_v[W-2], exp_v[DSIZE-1:0]);
          end
        end
      end
      checks++;
      if ((bus.gnt0 & bus.gnt1) !== 1'b0) begin
        errors++;
        $display("FAIL one_hot_gnt: gnt0=%b gnt1=%b, required at most one high", bus.gnt0, bus.gnt1);
      end
      pend = bus.gnt0 | bus.gnt1;
      if (bus.gnt1 === 1'b1) begin
        exp_q.push_back({1'b1, {1'b0, bus.a1} + {1'b0, bus.b1}});
      end else if (bus.gnt0 === 1'b1) begin
        exp_q.push_back({1'b0, {1'b0, bus.a0} + {1'b0, bus.b0}});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.res_ready = 1'b1;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_cout, bus.res_id, bus.gnt0, bus.gnt1, dbg_state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b cout=%b id=%b gnt0=%b gnt1=%b state=%b, required all 0",
               bus.res_valid, bus.res_cout, bus.res_id, bus.gnt0, bus.gnt1, dbg_state);
    end
    checks++;
    if (bus.res !== '0) begin
      errors++;
      $display("FAIL reset_res: got %h required 0", bus.res);
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.a0 = 16'h0005; bus.b0 = 16'h0003;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL single_gnt: gnt0=%b gnt1=%b required 1 0", bus.gnt0, bus.gnt1);
    end
    step();
    bus.req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res_cout, bus.res} !== {1'b1, 1'b0, 1'b0, 16'h0008}) begin
      errors++;
      $display("FAIL single_res: valid=%b id=%b cout=%b res=%h required 1 0 0 0008",
               bus.res_valid, bus.res_id, bus.res_cout, bus.res);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: res_valid=%b required 0", bus.res_valid);
    end
    step();
  endtask

  task automatic test_wrap();
    bus.req1 = 1'b1; bus.a1 = 16'hFFFF; bus.b1 = 16'h0002;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_gnt: gnt0=%b gnt1=%b required 0 1", bus.gnt0, bus.gnt1);
    end
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res_cout, bus.res} !== {1'b1, 1'b1, 1'b1, 16'h0001}) begin
      errors++;
      $display("FAIL wrap_res: valid=%b id=%b cout=%b res=%h required 1 1 1 0001",
               bus.res_valid, bus.res_id, bus.res_cout, bus.res);
    end
    step();
  endtask

  task automatic test_contention();
    logic [3:0] order;
`ifdef ADDER_ARB_RR_EN
    order = 4'b1010;
`else
    order = 4'b0000;
`endif
    bus.res_ready = 1'b1;
    bus.req0 = 1'b1; bus.a0 = 16'h0001; bus.b0 = 16'h0002;
    bus.req1 = 1'b1; bus.a1 = 16'h0010; bus.b1 = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.gnt1} !== {~order[i], order[i]}) begin
        errors++;
        $display("FAIL contention_order[%0d]: gnt0=%b gnt1=%b required winner %0d",
                 i, bus.gnt0, bus.gnt1, order[i]);
      end
      step();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 16'd100; bus.b0 = 16'd23;
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_gnt: gnt0=%b required 1", bus.gnt0);
    end
    step();
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.a1 = 16'd7; bus.b1 = 16'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.res_valid, dbg_state, bus.res} !== {1'b0, 1'b0, 1'b1, 1'b1, 16'd123}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: gnt0=%b gnt1=%b valid=%b state=%b res=%h required 0 0 1 1 %h",
                 i, bus.gnt0, bus.gnt1, bus.res_valid, dbg_state, bus.res, 16'd123);
      end
      step();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release_gnt: gnt0=%b gnt1=%b required 0 1", bus.gnt0, bus.gnt1);
    end
    step();
    bus.req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res} !== {1'b1, 1'b1, 16'd15}) begin
      errors++;
      $display("FAIL bp_new_res: valid=%b id=%b res=%h required 1 1 %h",
               bus.res_valid, bus.res_id, bus.res, 16'd15);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.res_ready = 1'b0;
    bus.req0 = 1'b1; bus.a0 = 16'd9; bus.b0 = 16'd9;
    step();
    bus.a0 = 16'd2; bus.b0 = 16'd2;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.gnt0} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_pre: valid=%b gnt0=%b required 1 0", bus.res_valid, bus.gnt0);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.res_valid, dbg_state, bus.gnt0, bus.res} !== {3'b000, 16'h0000}) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b state=%b gnt0=%b res=%h required 0 0 0 0000",
               bus.res_valid, dbg_state, bus.gnt0, bus.res);
    end
    step();
    @(negedge clk);
    checks++;
    if (bus.gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_held_gnt: gnt0=%b required 0 while rst high", bus.gnt0);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after_gnt: gnt0=%b required 1 after rst falls", bus.gnt0);
    end
    step();
    bus.req0 = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.res_valid, bus.res_id, bus.res} !== {1'b1, 1'b0, 16'd4}) begin
      errors++;
      $display("FAIL rstmid_res: valid=%b id=%b res=%h required 1 0 0004", bus.res_valid, bus.res_id, bus.res);
    end
    step();
  endtask

  task automatic test_random();
    logic g0, g1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      g0 = bus.gnt0;
      g1 = bus.gnt1;
      step();
      if (g0 || !bus.req0) begin
        bus.req0 = 1'($urandom_range(0, 1));
        bus.a0   = DSIZE'($urandom);
        bus.b0   = DSIZE'($urandom);
      end
      if (g1 || !bus.req1) begin
        bus.req1 = 1'($urandom_range(0, 1));
        bus.a1   = DSIZE'($urandom);
        bus.b1   = DSIZE'($urandom);
      end
      bus.res_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.res_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: queued=%0d valid=%b required 0 0", exp_q.size(), bus.res_valid);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
